// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit with private HI/LO registers.
// Results are computed combinationally from latched operands and committed on the last Busy edge.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    logic [CW-1:0] cnt;
    logic [31:0]   op_a, op_b;
    logic [1:0]    op_q;
    logic [63:0]   prod_s, prod_u, res;
    logic [31:0]   mag_a, mag_b, mag_q, mag_r, div_q, div_r;
    logic          sgn, div0;
    assign Busy   = cnt != '0;
    assign sgn    = !op_q[0];
    assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    assign prod_u = {32'b0, op_a} * {32'b0, op_b};
    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
    assign mag_a  = sgn && op_a[31] ? -op_a : op_a;
    assign mag_b  = sgn && op_b[31] ? -op_b : op_b;
    assign div0   = op_q[1] && op_b == '0;
    assign mag_q  = div0 ? '0 : mag_a / mag_b;
    assign mag_r  = div0 ? '0 : mag_a % mag_b;
    assign div_q  = sgn && (op_a[31] ^ op_b[31]) ? -mag_q : mag_q;
    assign div_r  = sgn && op_a[31] ? -mag_r : mag_r;
    assign res    = op_q == 2'd0 ? prod_s : op_q == 2'd1 ? prod_u : {div_r, div_q};
    always_ff @(posedge CLK) begin
        if (Reset) begin
            HI  <= '0;
            LO  <= '0;
            cnt <= '0;
        end else if (Busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1) && !div0) {HI, LO} <= res;
        end else if (Start && !Op[2]) begin
            op_a <= A;
            op_b <= B;
            op_q <= Op[1:0];
            cnt  <= Op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (Start && Op == 3'd4) begin
            HI <= A;
        end else if (Start && Op == 3'd5) begin
            LO <= A;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed checks of md_unit against a behavioural HI/LO model.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;
    logic        CLK = 0, Reset = 1, Start = 0;
    logic [2:0]  Op = '0;
    logic [31:0] A = '0, B = '0;
    logic        Busy;
    logic [31:0] HI, LO;
    int n_cmp = 0, n_bad = 0;
    bit chk = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int m_rem = 0;
    bit m_keep = 0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    // Returns {keep_old, hi, lo} for an arithmetic op, from plain integer arithmetic.
    function automatic logic [64:0] model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op == 2'd0) r = sa * sb;
        else if (op == 2'd1) r = ua * ub;
        else if (b == 0) return {1'b1, 64'b0};
        else if (op == 2'd2) r = {32'(sa % sb), 32'(sa / sb)};
        else r = {a % b, a / b};
        return {1'b0, r};
    endfunction

    always @(posedge CLK) begin
        logic [64:0] r;
        if (Reset) begin
            m_hi <= '0; m_lo <= '0; m_rem <= 0;
        end else if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1 && !m_keep) begin m_hi <= p_hi; m_lo <= p_lo; end
        end else if (Start && Op < 4) begin
            r = model_op(Op[1:0], A, B);
            {m_keep, p_hi, p_lo} <= r;
            m_rem <= Op[1] ? DC : MC;
        end else if (Start && Op == 4) m_hi <= A;
        else if (Start && Op == 5) m_lo <= A;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) if (chk) begin
        check("busy", 32'(Busy), 32'(m_rem != 0));
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
    end

    task automatic cyc(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        Start = s; Op = o; A = a; B = b;
        @(negedge CLK);
    endtask

    // Issue one op, then hold or scramble inputs until Busy drops; n counts Busy cycles.
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise, output int n);
        cyc(1'b1, op, a, b);
        n = 0;
        while (Busy && n < 40) begin
            if (noise) cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
            else cyc(Start, Op, A, B);
            n++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        @(negedge CLK);
        cyc(1'b1, 3'd0, 32'd1, 32'd1);
        cyc(1'b0, 3'd0, 32'd0, 32'd0);
        Reset = 0;
        chk = 1;
        check("reset_hi", HI, 32'h0);
        check("reset_lo", LO, 32'h0);
        check("reset_busy", 32'(Busy), 32'h0);

        run(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1, n);
        check("mult_cycles", n, MC);
        check("mult_hi", HI, 32'hFFFFFFFF);
        check("mult_lo", LO, 32'hFFFFFFFA);
        run(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, n);
        check("multu_cycles", n, MC);
        check("multu_hi", HI, 32'h00000002);
        check("multu_lo", LO, 32'hFFFFFFFA);
        run(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, n);
        check("div_cycles", n, DC);
        check("div_lo", LO, 32'hFFFFFFFD);
        check("div_hi", HI, 32'hFFFFFFFF);
        run(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, n);
        check("divu_lo", LO, 32'h7FFFFFFC);
        check("divu_hi", HI, 32'h00000001);
        run(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, n);
        check("divovf_lo", LO, 32'h80000000);
        check("divovf_hi", HI, 32'h0);

        cyc(1'b1, 3'd4, 32'h11, 32'h0);
        check("mthi", HI, 32'h11);
        cyc(1'b1, 3'd5, 32'h22, 32'h0);
        check("mtlo", LO, 32'h22);
        check("mt_busy", 32'(Busy), 32'h0);
        run(3'd2, 32'h1234, 32'h0, 1'b1, n);
        check("div0_cycles", n, DC);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);

        cyc(1'b1, 3'd4, 32'hDEADBEEF, 32'h0);
        check("mthi2", HI, 32'hDEADBEEF);
        cyc(1'b1, 3'd5, 32'h12345678, 32'h0);
        check("mtlo2", LO, 32'h12345678);
        check("mthi2_keep", HI, 32'hDEADBEEF);

        run(3'd0, 32'd7, 32'd6, 1'b0, n);
        check("b2b_first_cycles", n, MC);
        check("b2b_first_lo", LO, 32'd42);
        check("b2b_gap_busy", 32'(Busy), 32'h0);
        cyc(1'b1, 3'd1, 32'd5, 32'd9);
        check("b2b_accept_busy", 32'(Busy), 32'h1);
        while (Busy && n < 80) begin cyc(1'b0, 3'd0, 32'd0, 32'd0); n++; end
        check("b2b_second_lo", LO, 32'd45);

        cyc(1'b1, 3'd2, 32'd100, 32'd7);
        repeat (3) cyc(1'b0, 3'd0, 32'd0, 32'd0);
        Reset = 1;
        cyc(1'b1, 3'd4, 32'hFFFF, 32'd0);
        Reset = 0;
        check("abort_busy", 32'(Busy), 32'h0);
        check("abort_hi", HI, 32'h0);
        check("abort_lo", LO, 32'h0);
        repeat (12) cyc(1'b0, 3'd0, 32'd0, 32'd0);
        check("abort_late_hi", HI, 32'h0);
        check("abort_late_lo", LO, 32'h0);

        repeat (600) begin
            Reset = ($urandom_range(0, 63) == 0);
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick(), pick());
        end
        Reset = 0;
        repeat (12) cyc(1'b0, 3'd0, 32'd0, 32'd0);
        chk = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the MIPS datapath. It sits directly downstream of the general register file and consumes its two read ports (rs on `A`, rt on `B`). It executes MULT/MULTU/DIV/DIVU over a fixed latency and holds the results in private HI/LO registers. It also services MTHI/MTLO, and exposes HI/LO for MFHI/MFLO plus a `Busy` flag that the control/stall logic uses.

## Interface
- `MULT_CYCLES`, default 5: number of Busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: number of Busy cycles for DIV/DIVU (≥1).
- `CLK`  in  1: clock; all state updates on its rising edge.
- `Reset`  in  1: reset, synchronous, active-high.
- `Start`  in  1: qualifies `Op` this cycle.
- `Op`  in  3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no effect).
- `A`  in  32: operand rs (GRF data1); also the MTHI/MTLO source.
- `B`  in  32: operand rt (GRF data2).
- `Busy`  out  1: high while an arithmetic operation is in flight.
- `HI`  out  32: HI register contents.
- `LO`  out  32: LO register contents.

## Operation
- State: `HI`, `LO`, latched operands `opA`/`opB`, latched op, down-counter `cnt`. `Busy = (cnt != 0)`.
- Reset (edge with `Reset`=1): `HI`=0, `LO`=0, `cnt`=0, `Busy`=0. Any in-flight operation is aborted with no result written. Reset overrides `Start`.
- Idle accept (edge, `Busy`=0, `Start`=1):
  - Op 0–3: latch `A`, `B` and op. Load `cnt` with MULT_CYCLES (ops 0/1) or DIV_CYCLES (ops 2/3). `HI`/`LO` are unchanged at this edge.
  - Op 4: `HI` ← `A`. Op 5: `LO` ← `A`. No Busy.
  - Op 6/7: no state change.
- `Start` while `Busy`=1 is ignored entirely, including MTHI/MTLO. Stall logic must hold the instruction until `Busy`=0.
- In flight (edge, `cnt`>1): `cnt` decrements. `A`/`B` may change freely because the latched copies are used.
- Completion (edge, `cnt`==1): write results and set `cnt` ← 0.
  - MULT: {`HI`,`LO`} ← signed 64-bit product of opA×opB.
  - MULTU: {`HI`,`LO`} ← unsigned 64-bit product.
  - DIV: `LO` ← quotient, truncated toward zero; `HI` ← remainder, with the sign of the dividend (opA).
  - DIVU: `LO` ← unsigned quotient; `HI` ← unsigned remainder.
  - DIV with 0x80000000 / 0xFFFFFFFF: `LO`=0x80000000, `HI`=0.
  - Divide by zero (opB=0, DIV or DIVU): `HI`/`LO` retain their prior values. The full DIV_CYCLES Busy latency is still served.
- The internal implementation may be a single-edge combinational result applied at completion, or an iterative datapath. Visible timing must match exactly.

## Timing
- The accept edge is E0. `Busy` is high in the N cycles after E0, where N = MULT_CYCLES or DIV_CYCLES.
- Results are written at edge E_N. `Busy` falls and the new `HI`/`LO` are visible in the same cycle after E_N.
- A new `Start` is accepted at E_N itself only if `Busy` was sampled 0. Busy is still 1 before E_N, so the earliest back-to-back accept is E_(N+1).
- MTHI/MTLO: write at the accept edge. The new value is visible in the next cycle. Latency is 1 and there is no Busy.
- `HI`/`LO`/`Busy` are pure register outputs with no combinational path from the inputs. MFHI/MFLO read `HI`/`LO` directly; the control unit must not issue MFHI/MFLO while `Busy`=1.

## Test plan
- Reset then idle: assert `Reset` one edge, including mid-DIV at cycle 4 of 10 → `HI`=`LO`=0 and `Busy`=0 at the next cycle. No result is written later.
- MULT A=0xFFFFFFFE, B=3, Start one cycle → `Busy` high exactly 5 cycles, then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFFA. MULTU with the same operands → `HI`=0x00000002, `LO`=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 → after 10 Busy cycles `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF. DIVU with the same operands → `LO`=0x7FFFFFFC, `HI`=0x00000001.
- Corner divisions:
  - DIV 0x80000000 / 0xFFFFFFFF → `LO`=0x80000000, `HI`=0.
  - DIV by B=0 with prior `HI`=0x11, `LO`=0x22 → `Busy` 10 cycles, after which `HI`=0x11, `LO`=0x22 unchanged.
- MTHI A=0xDEADBEEF then MTLO A=0x12345678 on consecutive cycles → `HI`/`LO` update one cycle after each, with `Busy` staying 0. Then, during a MULT, MTHI with A=0x1 → ignored; `HI` ends with the product's high word.
- Operand/Start isolation during MULT:
  - Change `A`/`B` every cycle while `Busy` → the result reflects the operands latched at E0.
  - Pulse `Start` with DIV during MULT Busy → ignored; `Busy` lasts exactly 5 cycles.
  - Start asserted continuously → the next operation is accepted at E_(N+1).
